// File: rtl/lwsw_mon_pkg.sv
// Shared types and constants for the load/store runtime-monitor symbol path.
package lwsw_mon_pkg;

  localparam logic [1:0] CLS_LW    = 2'b00;
  localparam logic [1:0] CLS_SW    = 2'b01;
  localparam logic [1:0] CLS_MEM   = 2'b10;
  localparam logic [1:0] CLS_OTHER = 2'b11;

  typedef struct packed {
    logic [1:0] cls;
    logic [5:0] payload;
  } sym_t;

  typedef enum logic [1:0] {IDLE, ARM, STREAM} state_e;

  // Priority lw > sw > mem; anything else is a non-memory instruction.
  function automatic logic [1:0] classify(input logic is_lw, input logic is_sw,
                                          input logic is_mem);
    if (is_lw)       return CLS_LW;
    else if (is_sw)  return CLS_SW;
    else if (is_mem) return CLS_MEM;
    else             return CLS_OTHER;
  endfunction

endpackage

// File: rtl/lwsw_sym_fifo.sv
// Multi-write, single-read symbol FIFO; lanes are packed into consecutive slots in lane order.
module lwsw_sym_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NR_WR = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic [NR_WR-1:0]       wr_en_i,
  input  logic [NR_WR*WIDTH-1:0] wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic [CW-1:0]          free_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic [AW-1:0]    off [NR_WR];
  logic [CW-1:0]    n_wr;

  always_comb begin
    n_wr = '0;
    for (int i = 0; i < NR_WR; i++) begin
      off[i] = n_wr[AW-1:0];
      if (wr_en_i[i]) n_wr = n_wr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_WR; i++) begin
      if (wr_en_i[i] && !flush_i) mem_q[wptr_q + off[i]] <= wr_data_i[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + n_wr[AW-1:0];
      rptr_q  <= rptr_q + AW'(rd_en_i);
      count_q <= count_q + n_wr - CW'(rd_en_i);
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign empty_o   = (count_q == '0);
  assign free_o    = CW'(DEPTH) - count_q;

endmodule

// File: rtl/lwsw_symbol_encoder.sv
// Classifies committed instructions into automaton symbols, buffers them and streams them
// to the lwsw monitor with its run strobe and reset sequenced around the first symbol.
module lwsw_symbol_encoder
  import lwsw_mon_pkg::*;
#(
  parameter int unsigned NR_COMMIT = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_i,
  input  logic [NR_COMMIT-1:0]   commit_valid_i,
  input  logic [NR_COMMIT-1:0]   commit_is_lw_i,
  input  logic [NR_COMMIT-1:0]   commit_is_sw_i,
  input  logic [NR_COMMIT-1:0]   commit_is_mem_i,
  input  logic [6*NR_COMMIT-1:0] commit_payload_i,
  output logic [7:0]             symbol_o,
  output logic                   run_o,
  output logic                   mon_reset_o,
  output logic                   overflow_o,
  output logic [DROP_W-1:0]      drop_cnt_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned NW = $clog2(NR_COMMIT + 1);
  localparam int unsigned SW = DROP_W + 1;

  state_e              state_q, state_d;
  logic [7:0]          symbol_q, symbol_d;
  logic                run_q, run_d;
  logic                mon_reset_q, mon_reset_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic                pop;
  logic [7:0]          head;
  logic                empty;
  logic [CW-1:0]       free, avail, used;
  logic [NR_COMMIT-1:0] wr_en;
  logic [NR_COMMIT*8-1:0] wr_data;
  logic [NW-1:0]       n_drop;
  logic [SW-1:0]       drop_sum;
  sym_t                sym;

  lwsw_sym_fifo #(
    .DEPTH (DEPTH),
    .NR_WR (NR_COMMIT),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (!enable_i),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .empty_o   (empty),
    .free_o    (free)
  );

  always_comb begin
    state_d     = state_q;
    symbol_d    = symbol_q;
    run_d       = 1'b0;
    mon_reset_d = mon_reset_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        mon_reset_d = 1'b1;
        state_d     = ARM;
      end
      ARM: begin
        mon_reset_d = 1'b1;
        if (!empty) begin
          pop         = 1'b1;
          run_d       = 1'b1;
          symbol_d    = head;
          mon_reset_d = 1'b0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        mon_reset_d = 1'b0;
        if (!empty) begin
          pop      = 1'b1;
          run_d    = 1'b1;
          symbol_d = head;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable_i) begin
      state_d     = IDLE;
      pop         = 1'b0;
      run_d       = 1'b0;
      mon_reset_d = 1'b1;
    end
  end

  // A same-cycle pop frees a slot for this cycle's writes.
  always_comb begin
    avail   = free + CW'(pop);
    used    = '0;
    n_drop  = '0;
    wr_en   = '0;
    wr_data = '0;
    sym     = '0;
    for (int i = 0; i < NR_COMMIT; i++) begin
      sym.cls     = classify(commit_is_lw_i[i], commit_is_sw_i[i], commit_is_mem_i[i]);
      sym.payload = commit_payload_i[i*6 +: 6];
      wr_data[i*8 +: 8] = sym;
      if (enable_i && commit_valid_i[i]) begin
        if (used < avail) begin
          wr_en[i] = 1'b1;
          used     = used + CW'(1);
        end else begin
          n_drop = n_drop + NW'(1);
        end
      end
    end
    drop_sum   = {1'b0, drop_cnt_q} + SW'(n_drop);
    drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    overflow_d = overflow_q || (n_drop != '0);
    if (!enable_i) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      symbol_q    <= '0;
      run_q       <= 1'b0;
      mon_reset_q <= 1'b1;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      symbol_q    <= symbol_d;
      run_q       <= run_d;
      mon_reset_q <= mon_reset_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign symbol_o    = symbol_q;
  assign run_o       = run_q;
  assign mon_reset_o = mon_reset_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_lwsw_symbol_encoder.sv
// Randomized and directed scoreboard bench for lwsw_symbol_encoder.
module tb_lwsw_symbol_encoder;

  localparam int NR     = 2;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int CNT_MAX = (1 << DROP_W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable_i;
  logic [NR-1:0]   commit_valid_i, commit_is_lw_i, commit_is_sw_i, commit_is_mem_i;
  logic [6*NR-1:0] commit_payload_i;
  logic [7:0]      symbol_o;
  logic            run_o, mon_reset_o, overflow_o;
  logic [DROP_W-1:0] drop_cnt_o;

  lwsw_symbol_encoder #(
    .NR_COMMIT (NR),
    .DEPTH     (DEPTH),
    .DROP_W    (DROP_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable_i         (enable_i),
    .commit_valid_i   (commit_valid_i),
    .commit_is_lw_i   (commit_is_lw_i),
    .commit_is_sw_i   (commit_is_sw_i),
    .commit_is_mem_i  (commit_is_mem_i),
    .commit_payload_i (commit_payload_i),
    .symbol_o         (symbol_o),
    .run_o            (run_o),
    .mon_reset_o      (mon_reset_o),
    .overflow_o       (overflow_o),
    .drop_cnt_o       (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sym;
    int cyc;
  } sym_exp_t;

  typedef struct {
    bit monrst;
    bit ovf;
    int cnt;
    bit chk_sym;
    int cyc;
  } st_exp_t;

  sym_exp_t sym_q[$];
  st_exp_t  st_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of symbols plus a coarse "phase" of the hand-off.
  int  mq[$];
  bit  m_started;   // monitor has been armed since the last flush
  bit  m_streaming; // first symbol already handed over
  bit  m_ovf;
  int  m_cnt;

  function automatic int sym_of(bit lw, bit sw, bit mem, int payload);
    int base;
    base = lw ? 0 : sw ? 64 : mem ? 128 : 192;
    return base + payload;
  endfunction

  task automatic step(input bit rst, input bit en, input logic [NR-1:0] v, input logic [NR-1:0] l,
                      input logic [NR-1:0] s, input logic [NR-1:0] m,
                      input logic [6*NR-1:0] p);
    int space, drops;
    st_exp_t st;
    reset = rst; enable_i = en;
    commit_valid_i = v; commit_is_lw_i = l; commit_is_sw_i = s; commit_is_mem_i = m;
    commit_payload_i = p;
    st.chk_sym = rst;
    if (rst || !en) begin
      mq.delete();
      m_started = 0; m_streaming = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      if (m_started && mq.size() > 0) begin
        sym_q.push_back('{sym: mq.pop_front(), cyc: cyc + 1});
        m_streaming = 1;
      end
      m_started = 1;
      space = DEPTH - mq.size();
      drops = 0;
      for (int i = 0; i < NR; i++) begin
        if (v[i]) begin
          if (space > 0) begin
            mq.push_back(sym_of(l[i], s[i], m[i], int'(p[i*6 +: 6])));
            space--;
          end else drops++;
        end
      end
      m_cnt = (m_cnt + drops > CNT_MAX) ? CNT_MAX : m_cnt + drops;
      if (drops > 0) m_ovf = 1;
    end
    st.monrst = !m_streaming;
    st.ovf = m_ovf;
    st.cnt = m_cnt;
    st.cyc = cyc + 1;
    st_q.push_back(st);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1'b0, en, '0, '0, '0, '0, '0);
  endtask

  task automatic rand_step(input bit allow_flush);
    bit rst, en;
    rst = allow_flush && ($urandom_range(0, 79) == 0);
    en  = !allow_flush || ($urandom_range(0, 24) != 0);
    step(rst, en, NR'($urandom), NR'($urandom), NR'($urandom), NR'($urandom), (6*NR)'($urandom));
  endtask

  always @(negedge clk) begin
    sym_exp_t e;
    st_exp_t  st;
    if (run_o) begin
      checks++;
      if (sym_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_run cyc=%0d got symbol %0d, expected no symbol", cyc, symbol_o);
      end else begin
        e = sym_q.pop_front();
        if (e.cyc != cyc || int'(symbol_o) != e.sym) begin
          errors++;
          $display("FAIL symbol cyc=%0d got %0d, expected %0d at cyc %0d",
                   cyc, symbol_o, e.sym, e.cyc);
        end
      end
    end else if (sym_q.size() > 0 && sym_q[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = sym_q.pop_front();
      $display("FAIL missing_run cyc=%0d got run_o=0, expected symbol %0d", cyc, e.sym);
    end
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      st = st_q.pop_front();
      checks++;
      if (mon_reset_o != st.monrst || overflow_o != st.ovf || int'(drop_cnt_o) != st.cnt ||
          (st.chk_sym && (symbol_o != 8'd0 || run_o != 1'b0))) begin
        errors++;
        $display("FAIL status cyc=%0d got mon_reset=%0b ovf=%0b cnt=%0d sym=%0d run=%0b, expected mon_reset=%0b ovf=%0b cnt=%0d%s",
                 cyc, mon_reset_o, overflow_o, drop_cnt_o, symbol_o, run_o, st.monrst, st.ovf,
                 st.cnt, st.chk_sym ? " sym=0 run=0" : "");
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    // First lw, payload 5: two cycles to the monitor.
    idle(3, 1'b1);
    step(1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 12'd5);
    idle(3, 1'b1);
    // sw payload 2 on port 0, non-mem payload 63 on port 1 -> 66 then 255.
    step(1'b0, 1'b1, 2'b11, 2'b00, 2'b01, 2'b00, {6'd63, 6'd2});
    idle(4, 1'b1);
    // Sustained dual commits overfill the FIFO and saturate the drop counter.
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b11, (6*NR)'($urandom));
    checks++;
    if (drop_cnt_o !== 8'hFF || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL saturation got cnt=%0d ovf=%0b, expected cnt=255 ovf=1", drop_cnt_o,
               overflow_o);
    end
    // Flush while symbols are still buffered.
    idle(1, 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 2'b11, 2'b10, 2'b01, 2'b00, (6*NR)'($urandom));
    idle(1, 1'b0);
    idle(2, 1'b0);
    // Reset mid-stream, then only post-reset commits may appear.
    idle(1, 1'b1);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, (6*NR)'($urandom));
    step(1'b1, 1'b1, 2'b11, 2'b01, 2'b00, 2'b00, (6*NR)'($urandom));
    step(1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 12'd9);
    idle(4, 1'b1);
    for (int i = 0; i < 400; i++) rand_step(1'b0);
    for (int i = 0; i < 1500; i++) rand_step(1'b1);
    idle(DEPTH + 4, 1'b1);
    idle(2, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
